// File: rtl/uart_rx_buf_ctrl.sv
// rtl/uart_rx_buf_ctrl.sv - UART receive buffer controller with error tags, timeout and interrupts
//
// Buffers characters from the receive shift register (RSR) in a DEPTH-entry
// FIFO, each entry tagged with its parity-error status. It raises rx_full as
// back-pressure toward the RSR and runs a character-timeout timer counted in
// bit times. It produces a threshold interrupt and a timeout interrupt, and
// keeps sticky overflow and frame-error flags.
//
// Ports:
//   clk, rst        single clock, synchronous active-high reset
//   btick           one-clk pulse per bit time
//   rx_wr_en/rx_data/rx_parity_err/rx_frame_err   RSR side
//   rx_full         back-pressure to the RSR
//   rd_req          host pop request
//   rd_data/rd_perr/rd_valid   popped entry, valid one clk after rd_req
//   thr             irq_thr threshold (0 disables)
//   to_en/to_bits   timeout enable and length in bit times (0 disables)
//   err_clr         clears ovr_err, fe_stat and irq_to
//   count/empty     occupancy
//   ovr_err/fe_stat/irq_thr/irq_to   status and interrupts
module uart_rx_buf_ctrl #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          btick,
    input  logic          rx_wr_en,
    input  logic [7:0]    rx_data,
    input  logic          rx_parity_err,
    input  logic          rx_frame_err,
    output logic          rx_full,
    input  logic          rd_req,
    output logic [7:0]    rd_data,
    output logic          rd_perr,
    output logic          rd_valid,
    input  logic [AW:0]   thr,
    input  logic          to_en,
    input  logic [7:0]    to_bits,
    input  logic          err_clr,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          ovr_err,
    output logic          fe_stat,
    output logic          irq_thr,
    output logic          irq_to
);

    typedef enum logic [1:0] {T_IDLE, T_RUN, T_EXP} t_state_e;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [8:0]    r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_pe_pend;
    logic          r_fe_prev;
    logic          r_ovr_err;
    logic          r_fe_stat;
    logic          r_irq_to;
    logic          r_rd_valid;
    logic [7:0]    r_rd_data;
    logic          r_rd_perr;
    t_state_e      r_state;
    logic [7:0]    r_timer;

    logic          w_full;
    logic          w_empty;
    logic          w_rd;
    logic          w_wr;
    logic          w_ovf;
    logic          w_active;
    logic          w_to_ok;
    logic [AW:0]   w_count_nxt;
    logic          w_empty_nxt;

    assign w_full   = (r_count == FULL_CNT);
    assign w_empty  = (r_count == '0);
    assign w_rd     = rd_req && !w_empty;
    // A pop in the same cycle frees a slot, so a write into a full FIFO is
    // still accepted when paired with a read.
    assign w_wr     = rx_wr_en && (!w_full || w_rd);
    assign w_ovf    = rx_wr_en && !w_wr;
    assign w_active = w_wr || w_rd;
    assign w_to_ok  = to_en && (to_bits != 8'd0);

    assign w_count_nxt = r_count + {{AW{1'b0}}, w_wr} - {{AW{1'b0}}, w_rd};
    assign w_empty_nxt = (w_count_nxt == '0);

    // Storage is not reset; stale contents are unreachable once pointers and
    // count return to zero.
    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= {rx_parity_err | r_pe_pend, rx_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_pe_pend  <= 1'b0;
            r_fe_prev  <= 1'b0;
            r_ovr_err  <= 1'b0;
            r_fe_stat  <= 1'b0;
            r_rd_valid <= 1'b0;
            r_rd_data  <= 8'd0;
            r_rd_perr  <= 1'b0;
        end else begin
            r_count    <= w_count_nxt;
            r_rd_valid <= w_rd;
            r_fe_prev  <= rx_frame_err;
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr  <= r_rd_ptr + 1'b1;
                r_rd_data <= r_mem[r_rd_ptr][7:0];
                r_rd_perr <= r_mem[r_rd_ptr][8];
            end
            // Parity error arrives ahead of the strobe; hold it until the
            // character it belongs to is written or dropped.
            if (rx_wr_en) begin
                r_pe_pend <= 1'b0;
            end else if (rx_parity_err) begin
                r_pe_pend <= 1'b1;
            end
            if (err_clr) begin
                r_ovr_err <= 1'b0;
                r_fe_stat <= 1'b0;
            end else begin
                if (w_ovf) begin
                    r_ovr_err <= 1'b1;
                end
                if (rx_frame_err && !r_fe_prev) begin
                    r_fe_stat <= 1'b1;
                end
            end
        end
    end

    // Character-timeout sequencer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= T_IDLE;
            r_timer  <= 8'd0;
            r_irq_to <= 1'b0;
        end else begin
            if (w_empty_nxt || !w_to_ok) begin
                r_state <= T_IDLE;
                r_timer <= 8'd0;
            end else begin
                case (r_state)
                    T_IDLE: begin
                        r_state <= T_RUN;
                        r_timer <= 8'd0;
                    end
                    T_RUN: begin
                        if (w_active) begin
                            r_timer <= 8'd0;
                        end else if (btick) begin
                            if (r_timer == to_bits - 8'd1) begin
                                r_state  <= T_EXP;
                                r_irq_to <= 1'b1;
                            end else begin
                                r_timer <= r_timer + 8'd1;
                            end
                        end
                    end
                    T_EXP: begin
                        if (w_active) begin
                            r_state <= T_RUN;
                            r_timer <= 8'd0;
                        end
                    end
                    default: begin
                        r_state <= T_IDLE;
                        r_timer <= 8'd0;
                    end
                endcase
            end
            // Clearing takes priority over a same-cycle expiry.
            if (err_clr || w_rd) begin
                r_irq_to <= 1'b0;
            end
        end
    end

    assign count    = r_count;
    assign empty    = w_empty;
    assign rx_full  = w_full;
    assign irq_thr  = (thr != '0) && (r_count >= thr);
    assign rd_valid = r_rd_valid;
    assign rd_data  = r_rd_data;
    assign rd_perr  = r_rd_perr;
    assign ovr_err  = r_ovr_err;
    assign fe_stat  = r_fe_stat;
    assign irq_to   = r_irq_to;

endmodule
